// File: rtl/demux_1x2_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux_1x2_reg
// Brief    : Registered 1:2 demultiplexer, one-entry valid/ready hold per
//            channel. Optional drain counters enabled by macro DEMUX_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1x2_reg #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready,
`ifdef DEMUX_CNT_EN
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
`endif
  output logic              busy
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            r_state [2];
  state_t            w_state_nxt [2];
  logic [DATA_W-1:0] r_data [2];
  logic [1:0]        w_valid;
  logic [1:0]        w_ready_in;
  logic [1:0]        w_accept;
  logic [1:0]        w_drain;
  logic [1:0]        w_slot_free;

  assign w_ready_in = {out1_ready, out0_ready};

  // A slot can take a new item if empty or being drained this same cycle.
  assign w_slot_free = ~w_valid | w_ready_in;
  assign in_ready    = !flush && (in_sel ? w_slot_free[1] : w_slot_free[0]);

  genvar k;
  generate
    for (k = 0; k < 2; k++) begin : g_ch
      assign w_valid[k]  = (r_state[k] == ST_FULL);
      assign w_accept[k] = in_valid && in_ready && (in_sel == k[0]);
      assign w_drain[k]  = w_valid[k] && w_ready_in[k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state[k] <= ST_EMPTY;
        end else begin
          r_state[k] <= w_state_nxt[k];
        end
      end

      always_comb begin
        w_state_nxt[k] = r_state[k];
        if (flush) begin
          w_state_nxt[k] = ST_EMPTY;
        end else begin
          case (r_state[k])
            ST_EMPTY: if (w_accept[k]) w_state_nxt[k] = ST_FULL;
            ST_FULL:  if (w_drain[k] && !w_accept[k]) w_state_nxt[k] = ST_EMPTY;
            default:  w_state_nxt[k] = ST_EMPTY;
          endcase
        end
      end

      // Data only moves on an accept, so a stalled entry stays stable.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data[k] <= '0;
        end else if (w_accept[k]) begin
          r_data[k] <= in_data;
        end
      end
    end
  endgenerate

  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out0_data  = r_data[0];
  assign out1_data  = r_data[1];
  assign busy       = w_valid[0] | w_valid[1];

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Counts consumer-side transfers, including those in a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_drain[0]) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_drain[1]) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_1x2_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1x2_reg
// Brief    : Self-checking bench for demux_1x2_reg against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1x2_reg;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [DATA_W-1:0] in_data;
  logic              in_sel;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out0_data;
  logic              out0_valid;
  logic              out0_ready;
  logic [DATA_W-1:0] out1_data;
  logic              out1_valid;
  logic              out1_ready;
  logic              busy;
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;
`endif

  always #5 clk = ~clk;

  demux_1x2_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
`ifdef DEMUX_CNT_EN
    .cnt0       (cnt0),
    .cnt1       (cnt1),
`endif
    .busy       (busy)
  );

  // Reference: each channel is a queue of capacity one.
  logic [DATA_W-1:0] m_q0[$];
  logic [DATA_W-1:0] m_q1[$];
  logic [DATA_W-1:0] m_last0, m_last1;
  bit                m_stale0, m_stale1;
  int                m_drains0, m_drains1;
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q0.delete();
    m_q1.delete();
    m_last0 = '0; m_last1 = '0;
    m_stale0 = 0; m_stale1 = 0;
    m_drains0 = 0; m_drains1 = 0;
  endtask

  // Called just after a rising edge with inputs applied; compares at the
  // falling edge, then advances the model across the next rising edge.
  task automatic cycle();
    bit v0, v1, rdy, acc, d0, d1;
    @(negedge clk);
    v0  = (m_q0.size() != 0);
    v1  = (m_q1.size() != 0);
    rdy = !flush && (in_sel ? (!v1 || out1_ready) : (!v0 || out0_ready));
    check("in_ready",   in_ready,   rdy);
    check("out0_valid", out0_valid, v0);
    check("out1_valid", out1_valid, v1);
    check("busy",       busy,       v0 || v1);
    if (v0 || !m_stale0) check("out0_data", out0_data, v0 ? m_q0[0] : m_last0);
    if (v1 || !m_stale1) check("out1_data", out1_data, v1 ? m_q1[0] : m_last1);
`ifdef DEMUX_CNT_EN
    check("cnt0", cnt0, m_drains0 % (1 << CNT_W));
    check("cnt1", cnt1, m_drains1 % (1 << CNT_W));
`endif
    acc = in_valid && rdy;
    d0  = v0 && out0_ready;
    d1  = v1 && out1_ready;
    @(posedge clk);
    #1;
    if (d0) begin void'(m_q0.pop_front()); m_drains0++; end
    if (d1) begin void'(m_q1.pop_front()); m_drains1++; end
    if (flush) begin
      m_q0.delete(); m_q1.delete();
      m_stale0 = 1; m_stale1 = 1;
    end else if (acc) begin
      if (in_sel) begin m_q1.push_back(in_data); m_last1 = in_data; m_stale1 = 0; end
      else        begin m_q0.push_back(in_data); m_last0 = in_data; m_stale0 = 0; end
    end
  endtask

  task automatic drive(input bit f, input bit v, input bit s, input logic [7:0] d,
                       input bit r0, input bit r1);
    flush = f; in_valid = v; in_sel = s; in_data = d;
    out0_ready = r0; out1_ready = r1;
    cycle();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_v0", out0_valid, 0);
    check("rst_async_v1", out1_valid, 0);
    check("rst_async_rdy", in_ready, !flush);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 0; in_valid = 0; in_sel = 0; in_data = '0;
    out0_ready = 0; out1_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_v0", out0_valid, 0);
    check("rst_v1", out1_valid, 0);
    check("rst_d0", out0_data, 0);
    check("rst_d1", out1_data, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy_sel0", in_ready, 1);
    in_sel = 1; #1;
    check("rst_rdy_sel1", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    drive(0, 0, 0, 8'h00, 0, 0);

    // Single route
    drive(0, 1, 0, 8'hA5, 1, 1);
    check("route0_v", out0_valid, 1);
    check("route0_d", out0_data, 8'hA5);
    check("route0_v1", out1_valid, 0);
    drive(0, 1, 1, 8'h3C, 1, 1);
    check("route1_d", out1_data, 8'h3C);
    drive(0, 0, 0, 8'h00, 1, 1);

    // Back-pressure isolation
    drive(0, 1, 0, 8'h11, 0, 1);
    in_valid = 0; in_sel = 0; #1;
    check("bp_rdy_sel0", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 8'h20 + 8'(i), 0, 1);
      check("bp_out1", out1_data, 8'h20 + i);
      check("bp_hold0", out0_data, 8'h11);
    end
    drive(0, 0, 0, 8'h00, 1, 1);

    // Full-throughput drain+refill on ch0
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 0, 8'(i), 1, 0);
      check("tp_valid", out0_valid, 1);
      check("tp_data", out0_data, i);
    end
    drive(0, 0, 0, 8'h00, 1, 1);

    // Flush collision
    drive(0, 1, 0, 8'h55, 0, 0);
    drive(0, 1, 1, 8'h66, 0, 0);
    drive(1, 1, 0, 8'h77, 0, 0);
    check("flush_v0", out0_valid, 0);
    check("flush_v1", out1_valid, 0);
    drive(0, 0, 0, 8'h00, 0, 0);

    // Mid-operation asynchronous reset
    drive(0, 1, 0, 8'h9A, 0, 0);
    drive(0, 1, 1, 8'h9B, 0, 0);
    async_reset();
    drive(0, 0, 0, 8'h00, 0, 0);

    // 257 drains on ch0 with one flush mid-stream (that item is not taken)
    for (int i = 0; i < 258; i++)
      drive(i == 100, 1, 0, 8'(i), 1, 1);
    drive(0, 0, 0, 8'h00, 1, 1);
`ifdef DEMUX_CNT_EN
    check("cnt0_wrap", cnt0, 1);
    check("cnt1_zero", cnt1, 0);
    drive(1, 0, 0, 8'h00, 0, 0);
    check("cnt0_flush", cnt0, 1);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset();
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
            8'($urandom), $urandom_range(0, 2) != 0, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
